// File: rtl/neural_pkg.sv
// -----------------------------------------------------------------------------
// neural_pkg
// Shared types and helpers for the neural frame serializer slice.
//   ser_state_t    : serializer FSM state (IDLE, SEND)
//   ch_id_width()  : default channel-index width for a given channel count
//   ch_mask_max_t  : channel mask sized for the largest supported frame
//   ch_count_t     : enabled-channel count for the largest supported frame
// -----------------------------------------------------------------------------
package neural_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int unsigned MAX_CHANNELS = 256;

    typedef logic [MAX_CHANNELS-1:0]      ch_mask_max_t;
    typedef logic [$clog2(MAX_CHANNELS):0] ch_count_t;

    // Index width for num_channels channels; never narrower than one bit.
    function automatic int ch_id_width(input int num_channels);
        return (num_channels <= 2) ? 1 : $clog2(num_channels);
    endfunction

endpackage

// File: rtl/neural_next_channel.sv
// -----------------------------------------------------------------------------
// neural_next_channel
// Combinational priority finder over a channel mask.
// Ports:
//   mask       in  : mask being walked (latched frame mask)
//   cur_idx    in  : index of the beat currently presented
//   first_mask in  : mask whose lowest set bit starts a new frame
//   next_idx   out : lowest set bit of mask strictly above cur_idx
//   has_next   out : a higher set bit exists (0 => current beat is eof)
//   first_idx  out : lowest set bit of first_mask (search from "-1")
// -----------------------------------------------------------------------------
module neural_next_channel
    import neural_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int CH_ID_WIDTH  = ch_id_width(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [CH_ID_WIDTH-1:0]  cur_idx,
    input  logic [NUM_CHANNELS-1:0] first_mask,
    output logic [CH_ID_WIDTH-1:0]  next_idx,
    output logic                    has_next,
    output logic [CH_ID_WIDTH-1:0]  first_idx
);

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        next_idx  = '0;
        has_next  = 1'b0;
        first_idx = '0;
        for (int unsigned i = NUM_CHANNELS; i > 0; i--) begin
            if (mask[i-1] && ((i - 1) > 32'(cur_idx))) begin
                next_idx = CH_ID_WIDTH'(i - 1);
                has_next = 1'b1;
            end
            if (first_mask[i-1]) begin
                first_idx = CH_ID_WIDTH'(i - 1);
            end
        end
    end

endmodule

// File: rtl/neural_frame_serializer.sv
// -----------------------------------------------------------------------------
// neural_frame_serializer
// Captures one multi-channel sample frame and streams only its enabled
// channels on a valid/ready interface, one beat per cycle, no bubbles
// between back-to-back frames. Frames strobed while busy are dropped and
// counted (saturating).
// Optional feature macro: NEURAL_SER_FRAME_SEQ_EN
//   defined   -> per-frame wrapping sequence number on out_frame_seq
//   undefined -> out_frame_seq tied to 0, no counter
// Ports:
//   sys_clk, rst_n   : clock, asynchronous active-low reset
//   channel_mask     : enabled channels, sampled at capture
//   frame_data_in    : unpacked sample array for the frame
//   frame_valid_in   : one-cycle frame strobe
//   frame_ready_out  : a strobe this cycle would be captured
//   out_data/out_channel/out_sof/out_eof/out_frame_seq : beat payload
//   out_valid/out_ready : stream handshake
//   drop_cnt         : saturating dropped-frame count
//   busy             : high while a frame is being sent
// -----------------------------------------------------------------------------
module neural_frame_serializer
    import neural_pkg::*;
#(
    parameter int NUM_CHANNELS   = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int CH_ID_WIDTH    = ch_id_width(NUM_CHANNELS),
    parameter int DROP_CNT_WIDTH = 8,
    parameter int SEQ_WIDTH      = 8
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [NUM_CHANNELS-1:0]   channel_mask,
    input  logic [DATA_WIDTH-1:0]     frame_data_in [NUM_CHANNELS],
    input  logic                      frame_valid_in,
    output logic                      frame_ready_out,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CH_ID_WIDTH-1:0]    out_channel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [SEQ_WIDTH-1:0]      out_frame_seq,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      busy
);

    ser_state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0]     shadow_data_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   shadow_mask_q;
    logic [CH_ID_WIDTH-1:0]    cur_ch_q, cur_ch_d;
    logic                      sof_q, sof_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    logic [CH_ID_WIDTH-1:0]    next_idx;
    logic [CH_ID_WIDTH-1:0]    first_idx;
    logic                      has_next;
    logic                      handshake;
    logic                      eof_hs;
    logic                      capture;
    logic                      drop;

    neural_next_channel #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_ID_WIDTH  (CH_ID_WIDTH)
    ) u_next_channel (
        .mask       (shadow_mask_q),
        .cur_idx    (cur_ch_q),
        .first_mask (channel_mask),
        .next_idx   (next_idx),
        .has_next   (has_next),
        .first_idx  (first_idx)
    );

    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    // eof is derived from the latched mask, so it stays stable under stall.
    assign out_eof   = busy && !has_next;
    assign handshake = out_valid && out_ready;
    assign eof_hs    = handshake && out_eof;

    // Ready during the eof handshake allows a no-bubble back-to-back capture.
    assign frame_ready_out = (state_q == IDLE) || eof_hs;

    // An all-zero mask is ignored outright: neither captured nor dropped.
    assign capture = frame_valid_in &&  frame_ready_out && (|channel_mask);
    assign drop    = frame_valid_in && !frame_ready_out && (|channel_mask);

    assign out_data    = shadow_data_q[cur_ch_q];
    assign out_channel = cur_ch_q;
    assign out_sof     = sof_q;
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        sof_d    = sof_q;
        if (capture) begin
            state_d  = SEND;
            cur_ch_d = first_idx;
            sof_d    = 1'b1;
        end else if (handshake) begin
            sof_d = 1'b0;
            if (out_eof) begin
                state_d = IDLE;
            end else begin
                cur_ch_d = next_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_ch_q      <= '0;
            sof_q         <= 1'b0;
            shadow_mask_q <= '0;
            drop_cnt_q    <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                shadow_data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            sof_q    <= sof_d;
            if (capture) begin
                shadow_mask_q <= channel_mask;
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                    shadow_data_q[i] <= frame_data_in[i];
                end
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

`ifdef NEURAL_SER_FRAME_SEQ_EN
    // seq_cnt_q is the number the next captured frame will carry.
    logic [SEQ_WIDTH-1:0] seq_cnt_q;
    logic [SEQ_WIDTH-1:0] seq_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt_q <= '0;
            seq_q     <= '0;
        end else if (capture) begin
            seq_q     <= seq_cnt_q;
            seq_cnt_q <= seq_cnt_q + SEQ_WIDTH'(1);
        end
    end

    assign out_frame_seq = seq_q;
`else
    assign out_frame_seq = '0;
`endif

endmodule

// File: tb/tb_neural_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_neural_frame_serializer
// Directed self-checking bench for neural_frame_serializer (16 x 16-bit).
// Expected sequence numbers follow NEURAL_SER_FRAME_SEQ_EN when defined.
// -----------------------------------------------------------------------------
module tb_neural_frame_serializer;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [15:0] channel_mask;
    logic [15:0] frame_data_in [16];
    logic        frame_valid_in;
    logic        frame_ready_out;
    logic [15:0] out_data;
    logic [3:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_frame_seq;
    logic [7:0]  drop_cnt;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int seq_ctr      = 0;

    always #5 sys_clk = ~sys_clk;

    neural_frame_serializer #(
        .NUM_CHANNELS   (16),
        .DATA_WIDTH     (16),
        .CH_ID_WIDTH    (4),
        .DROP_CNT_WIDTH (8),
        .SEQ_WIDTH      (8)
    ) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .channel_mask    (channel_mask),
        .frame_data_in   (frame_data_in),
        .frame_valid_in  (frame_valid_in),
        .frame_ready_out (frame_ready_out),
        .out_data        (out_data),
        .out_channel     (out_channel),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sof         (out_sof),
        .out_eof         (out_eof),
        .out_frame_seq   (out_frame_seq),
        .drop_cnt        (drop_cnt),
        .busy            (busy)
    );

    // Advance one cycle and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Expected sequence number for the next captured frame.
    task automatic next_seq(output logic [7:0] s);
`ifdef NEURAL_SER_FRAME_SEQ_EN
        s = 8'(seq_ctr);
`else
        s = 8'd0;
`endif
        seq_ctr++;
    endtask

    task automatic test_reset();
        logic [44:0] exp;
        rst_n = 1'b1; frame_valid_in = 1'b0; out_ready = 1'b0; channel_mask = '0;
        for (int i = 0; i < 16; i++) frame_data_in[i] = '0;
        #2 rst_n = 1'b0;
        #10;
        exp = {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1};
        tests_run++;
        if ({out_valid, out_data, out_channel, out_sof, out_eof, out_frame_seq,
             drop_cnt, busy, frame_ready_out} !== exp) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h",
                {out_valid, out_data, out_channel, out_sof, out_eof, out_frame_seq,
                 drop_cnt, busy, frame_ready_out}, exp);
        end
        @(negedge sys_clk) rst_n = 1'b1;
        step();
        seq_ctr = 0;
    endtask

    task automatic test_sweep();
        logic [7:0]  s;
        logic [30:0] exp;
        int          busy_cycles = 0;
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'h100 + i);
        channel_mask = 16'h00FF; out_ready = 1'b1; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        frame_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, (k == 0), (k == 7), 4'(k), 16'(16'h100 + k), s};
            tests_run++;
            if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
                tests_failed++;
                $display("FAIL sweep_beat%0d: got %h expected %h", k,
                    {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
            end
            if (busy === 1'b1) busy_cycles++;
            step();
        end
        tests_run++;
        if (busy_cycles != 8 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_busy: got cycles=%0d busy=%b valid=%b expected cycles=8 busy=0 valid=0",
                busy_cycles, busy, out_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  s;
        logic [30:0] exp;
        logic [3:0]  exp_ch [4] = '{4'd0, 4'd0, 4'd15, 4'd15};
        logic        rdy    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'hA000 + i);
        channel_mask = 16'h8001; out_ready = 1'b0; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        frame_valid_in = 1'b0;
        channel_mask   = 16'hFFFF;
        for (int j = 0; j < 4; j++) begin
            exp = {1'b1, (exp_ch[j] == 4'd0), (exp_ch[j] == 4'd15), exp_ch[j],
                   16'hA000 | 16'(exp_ch[j]), s};
            tests_run++;
            if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: got %h expected %h", j,
                    {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
            end
            out_ready = rdy[j];
            step();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_end: got valid=%b expected valid=0", out_valid);
        end
    endtask

    task automatic test_single();
        logic [7:0]  s;
        logic [30:0] exp;
        channel_mask = 16'h0010; out_ready = 1'b1; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        frame_valid_in = 1'b0;
        exp = {1'b1, 1'b1, 1'b1, 4'd4, 16'hA004, s};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
            tests_failed++;
            $display("FAIL single_beat: got %h expected %h",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_drop();
        logic [7:0]  s;
        logic [30:0] exp;
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'h100 + i);
        channel_mask = 16'h00FF; out_ready = 1'b1; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        frame_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, (k == 0), (k == 7), 4'(k), 16'(16'h100 + k), s};
            tests_run++;
            if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
                tests_failed++;
                $display("FAIL drop_sweep_beat%0d: got %h expected %h", k,
                    {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
            end
            frame_valid_in = (k == 3);
            step();
            frame_valid_in = 1'b0;
            if (k == 3) begin
                tests_run++;
                if (drop_cnt !== 8'd1) begin
                    tests_failed++;
                    $display("FAIL drop_count_one: got %0d expected 1", drop_cnt);
                end
            end
        end
        tests_run++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL drop_end: got valid=%b drop=%0d expected valid=0 drop=1", out_valid, drop_cnt);
        end

        // Hold a frame stalled and strobe 300 more frames into it.
        out_ready = 1'b0; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        for (int n = 0; n < 300; n++) begin
            step();
            if (n == 252 || n == 253 || n == 299) begin
                tests_run++;
                if (drop_cnt !== ((n == 252) ? 8'd254 : 8'd255)) begin
                    tests_failed++;
                    $display("FAIL drop_saturate_n%0d: got %0d expected %0d", n, drop_cnt,
                        (n == 252) ? 254 : 255);
                end
            end
        end
        frame_valid_in = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 16'h0100, s};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
            tests_failed++;
            $display("FAIL drop_stalled_hold: got %h expected %h",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        tests_run++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL drop_drain: got valid=%b drop=%0d expected valid=0 drop=255", out_valid, drop_cnt);
        end
    endtask

    task automatic test_mask_zero();
        channel_mask = 16'h0000; frame_valid_in = 1'b1;
        step();
        frame_valid_in = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL mask_zero: got valid=%b busy=%b drop=%0d expected 0 0 255",
                out_valid, busy, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  s;
        logic [44:0] exp;
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'h100 + i);
        channel_mask = 16'h00FF; out_ready = 1'b1; frame_valid_in = 1'b1;
        next_seq(s);
        step();
        frame_valid_in = 1'b0;
        step();
        step();
        tests_run++;
        if (out_channel !== 4'd2 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got ch=%0d valid=%b expected ch=2 valid=1", out_channel, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1};
        tests_run++;
        if ({out_valid, out_data, out_channel, out_sof, out_eof, out_frame_seq,
             drop_cnt, busy, frame_ready_out} !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid_values: got %h expected %h",
                {out_valid, out_data, out_channel, out_sof, out_eof, out_frame_seq,
                 drop_cnt, busy, frame_ready_out}, exp);
        end
        @(negedge sys_clk) rst_n = 1'b1;
        step();
        seq_ctr = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s0, s1;
        logic [30:0] exp;
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'h200 + i);
        channel_mask = 16'h0003; out_ready = 1'b1; frame_valid_in = 1'b1;
        next_seq(s0);
        step();
        frame_valid_in = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 16'h0200, s0};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first_sof: got %h expected %h",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
        end
        step();
        exp = {1'b1, 1'b0, 1'b1, 4'd1, 16'h0201, s0};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp
            || frame_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_eof: got %h ready=%b expected %h ready=1",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq},
                frame_ready_out, exp);
        end
        for (int i = 0; i < 16; i++) frame_data_in[i] = 16'(16'h300 + i);
        channel_mask = 16'h000C; frame_valid_in = 1'b1;
        next_seq(s1);
        step();
        frame_valid_in = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 4'd2, 16'h0302, s1};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second_sof: got %h expected %h",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
        end
        step();
        exp = {1'b1, 1'b0, 1'b1, 4'd3, 16'h0303, s1};
        tests_run++;
        if ({out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second_eof: got %h expected %h",
                {out_valid, out_sof, out_eof, out_channel, out_data, out_frame_seq}, exp);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL b2b_end: got valid=%b busy=%b drop=%0d expected 0 0 0",
                out_valid, busy, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stall();
        test_single();
        test_drop();
        test_mask_zero();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
